// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: requester count, select width,
// FSM state encodings and the watchdog counter sizing helper.
package mem_port_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Width needed to count 0..max_wait; never narrower than one bit.
  function automatic int wait_cnt_w(input int max_wait);
    int w;
    w = $clog2(max_wait + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward from ptr, mod 4.
module rr_picker
  import mem_port_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Walk from lowest priority to highest so the last hit is the winner.
  always_comb begin
    winner = '0;
    idx    = '0;
    any    = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/mux4.sv
// Existing 4:1 W-bit data mux with a 3-bit select; selects above 3 yield zero.
module mux4 #(
  parameter int W = 64
) (
  input  logic [2:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer sharing one memory port among four requesters,
// with a watchdog that aborts transactions the memory never acknowledges.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N        = 64,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  we,
  input  logic [N-1:0]     addr0,
  input  logic [N-1:0]     addr1,
  input  logic [N-1:0]     addr2,
  input  logic [N-1:0]     addr3,
  input  logic [N-1:0]     wdata0,
  input  logic [N-1:0]     wdata1,
  input  logic [N-1:0]     wdata2,
  input  logic [N-1:0]     wdata3,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             err,
  output logic [N-1:0]     rdata,
  output logic [SEL_W-1:0] sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_wdata,
  input  logic             mem_ack,
  input  logic [N-1:0]     mem_rdata,
  output logic             busy
);

  localparam int               CNT_W     = wait_cnt_w(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0  = NREQ'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] winner;
  logic             any;
  logic             timeout;

  rr_picker u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  mux4 #(.W(N)) u_addr_mux (
    .sel ({1'b0, sel}),
    .d0  (addr0),
    .d1  (addr1),
    .d2  (addr2),
    .d3  (addr3),
    .y   (mem_addr)
  );

  mux4 #(.W(N)) u_wdata_mux (
    .sel ({1'b0, sel}),
    .d0  (wdata0),
    .d1  (wdata1),
    .d2  (wdata2),
    .d3  (wdata3),
    .y   (mem_wdata)
  );

  assign mem_req = (state == BUSY);
  assign mem_we  = (state == BUSY) & we[sel];
  assign busy    = (state != IDLE);
  assign timeout = !mem_ack && (cnt == WAIT_LAST);

  // Completion outputs are loaded on the BUSY->DONE edge so they are visible during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      sel   <= '0;
      gnt   <= '0;
      done  <= '0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            sel   <= winner;
            gnt   <= ONE_HOT0 << winner;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack || timeout) begin
            if (mem_ack && !we[sel]) rdata <= mem_rdata;
            done  <= ONE_HOT0 << sel;
            err   <= timeout;
            gnt   <= '0;
            ptr   <= sel + SEL_W'(1);
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int N        = 64;
  localparam int MAX_WAIT = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req, we;
  logic [N-1:0] addr0, addr1, addr2, addr3;
  logic [N-1:0] wdata0, wdata1, wdata2, wdata3;
  logic [3:0]   gnt, done;
  logic         err;
  logic [N-1:0] rdata;
  logic [1:0]   sel;
  logic         mem_req, mem_we;
  logic [N-1:0] mem_addr, mem_wdata;
  logic         mem_ack;
  logic [N-1:0] mem_rdata;
  logic         busy;

  int checkCount = 0;
  int passCount  = 0;

  mem_port_arbiter #(.N(N), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .addr2     (addr2),
    .addr3     (addr3),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .wdata2    (wdata2),
    .wdata3    (wdata3),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .sel       (sel),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] w, input logic ack, input logic [N-1:0] rd);
    req       = r;
    we        = w;
    mem_ack   = ack;
    mem_rdata = rd;
  endtask

  initial begin
    logic [63:0] keptRdata;
    logic [1:0]  expSel;

    reset = 1'b1;
    addr0 = 64'h100; addr1 = 64'h110; addr2 = 64'h200; addr3 = 64'h300;
    wdata0 = 64'h0; wdata1 = 64'h11; wdata2 = 64'h55; wdata3 = 64'h33;
    applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
    step();
    step();
    reset = 1'b0;

    checkOutput("reset_gnt", 64'(gnt), 64'h0);
    checkOutput("reset_done", 64'(done), 64'h0);
    checkOutput("reset_err", 64'(err), 64'h0);
    checkOutput("reset_rdata", rdata, 64'h0);
    checkOutput("reset_sel", 64'(sel), 64'h0);
    checkOutput("reset_mem_req", 64'(mem_req), 64'h0);
    checkOutput("reset_mem_we", 64'(mem_we), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);

    // Single read by requester 0, ack in second BUSY cycle
    applyStimulus(4'b0001, 4'b0000, 1'b0, '0);
    step();
    checkOutput("rd_gnt_c1", 64'(gnt), 64'h1);
    checkOutput("rd_sel", 64'(sel), 64'h0);
    checkOutput("rd_mem_req", 64'(mem_req), 64'h1);
    checkOutput("rd_mem_addr", mem_addr, 64'h100);
    checkOutput("rd_mem_we", 64'(mem_we), 64'h0);
    checkOutput("rd_done_c1", 64'(done), 64'h0);
    step();
    checkOutput("rd_gnt_c2", 64'(gnt), 64'h1);
    applyStimulus(4'b0001, 4'b0000, 1'b1, 64'hDEAD);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
    checkOutput("rd_done", 64'(done), 64'h1);
    checkOutput("rd_gnt_cleared", 64'(gnt), 64'h0);
    checkOutput("rd_rdata", rdata, 64'hDEAD);
    checkOutput("rd_err", 64'(err), 64'h0);
    checkOutput("rd_busy_done", 64'(busy), 64'h1);
    step();
    checkOutput("rd_done_one_cycle", 64'(done), 64'h0);
    checkOutput("rd_busy_idle", 64'(busy), 64'h0);

    // ack while idle is ignored
    applyStimulus(4'b0000, 4'b0000, 1'b1, 64'hBAD);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
    checkOutput("idle_ack_rdata", rdata, 64'hDEAD);
    checkOutput("idle_ack_done", 64'(done), 64'h0);

    // Pointer advanced to 1: with all requesting, requester 1 wins first
    applyStimulus(4'b1111, 4'b0000, 1'b0, '0);
    step();
    checkOutput("ptr1_sel", 64'(sel), 64'h1);
    checkOutput("ptr1_gnt", 64'(gnt), 64'h2);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 64'h77);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
    checkOutput("ptr1_done", 64'(done), 64'h2);
    step();

    // Reset, then all four requesting with immediate ack: order 0,1,2,3,0
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      expSel = 2'(i % 4);
      step();
      checkOutput($sformatf("rr%0d_sel", i), 64'(sel), 64'(expSel));
      checkOutput($sformatf("rr%0d_gnt", i), 64'(gnt), 64'(4'b0001 << expSel));
      applyStimulus(4'b1111, 4'b0000, 1'b1, 64'h1000 + 64'(expSel));
      step();
      applyStimulus(4'b1111, 4'b0000, 1'b0, '0);
      checkOutput($sformatf("rr%0d_done", i), 64'(done), 64'(4'b0001 << expSel));
      checkOutput($sformatf("rr%0d_rdata", i), rdata, 64'h1000 + 64'(expSel));
      step();
      checkOutput($sformatf("rr%0d_gap", i), 64'(done), 64'h0);
    end
    keptRdata = 64'h1000;

    // Write by requester 2: rdata must not change
    applyStimulus(4'b0100, 4'b0100, 1'b0, '0);
    step();
    checkOutput("wr_sel", 64'(sel), 64'h2);
    checkOutput("wr_mem_we", 64'(mem_we), 64'h1);
    checkOutput("wr_mem_wdata", mem_wdata, 64'h55);
    checkOutput("wr_mem_addr", mem_addr, 64'h200);
    applyStimulus(4'b0100, 4'b0100, 1'b1, 64'hFFFF);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
    checkOutput("wr_done", 64'(done), 64'h4);
    checkOutput("wr_rdata_kept", rdata, keptRdata);
    checkOutput("wr_mem_we_off", 64'(mem_we), 64'h0);
    step();

    // Watchdog: requester 1, never acked; done and err at t+1+MAX_WAIT
    applyStimulus(4'b0010, 4'b0000, 1'b0, 64'hABCD);
    step();
    checkOutput("wd_gnt", 64'(gnt), 64'h2);
    for (int k = 2; k <= MAX_WAIT; k++) begin
      step();
      checkOutput($sformatf("wd_wait%0d_done", k), 64'(done), 64'h0);
      checkOutput($sformatf("wd_wait%0d_mem_req", k), 64'(mem_req), 64'h1);
    end
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
    checkOutput("wd_done", 64'(done), 64'h2);
    checkOutput("wd_err", 64'(err), 64'h1);
    checkOutput("wd_rdata_kept", rdata, keptRdata);
    checkOutput("wd_gnt_cleared", 64'(gnt), 64'h0);
    step();
    checkOutput("wd_err_pulse", 64'(err), 64'h0);

    // Next request served normally
    applyStimulus(4'b0001, 4'b0000, 1'b0, '0);
    step();
    checkOutput("post_wd_gnt", 64'(gnt), 64'h1);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 64'h0BEE);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
    checkOutput("post_wd_done", 64'(done), 64'h1);
    checkOutput("post_wd_err", 64'(err), 64'h0);
    checkOutput("post_wd_rdata", rdata, 64'h0BEE);
    step();

    // Reset in the middle of a BUSY transaction
    applyStimulus(4'b1000, 4'b0000, 1'b0, '0);
    step();
    checkOutput("mid_gnt", 64'(gnt), 64'h8);
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
    step();
    reset = 1'b0;
    checkOutput("mid_rst_gnt", 64'(gnt), 64'h0);
    checkOutput("mid_rst_busy", 64'(busy), 64'h0);
    checkOutput("mid_rst_mem_req", 64'(mem_req), 64'h0);
    checkOutput("mid_rst_done", 64'(done), 64'h0);
    checkOutput("mid_rst_rdata", rdata, 64'h0);
    step();
    checkOutput("mid_rst_no_done", 64'(done), 64'h0);
    applyStimulus(4'b1111, 4'b0000, 1'b0, '0);
    step();
    checkOutput("mid_rst_ptr0", 64'(sel), 64'h0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 64'h42);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
    step();

    // Requester 1 drops req during BUSY; transaction still completes
    applyStimulus(4'b0010, 4'b0000, 1'b0, '0);
    step();
    checkOutput("drop_sel", 64'(sel), 64'h1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
    step();
    checkOutput("drop_gnt_held", 64'(gnt), 64'h2);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 64'h99);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
    checkOutput("drop_done", 64'(done), 64'h2);
    checkOutput("drop_rdata", rdata, 64'h99);
    step();
    checkOutput("drop_idle", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and sequencer that shares one N-bit memory port among four requesters (fetch, load/store, debug, DMA). It picks a winner, steers that requester's address and write data onto the port through the existing 4:1 N-bit muxes, holds the port until the memory acknowledges, and returns the result with a one-cycle completion pulse. A watchdog ends any transaction the memory never acknowledges.

## Interface
- N, 64, data and address width
- MAX_WAIT, 15, BUSY cycles without `mem_ack` before a watchdog abort (≥1)

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  4  per-requester request level, bit i = requester i
- we  in  4  per-requester write flag; 1 = write, 0 = read
- addr0..addr3  in  N  per-requester address
- wdata0..wdata3  in  N  per-requester write data
- gnt  out  4  one-hot grant, held for the whole transaction
- done  out  4  one-hot completion pulse, one cycle
- err  out  1  watchdog-abort pulse, coincident with `done`
- rdata  out  N  last read result, held until the next read completes
- sel  out  2  current winner index, drives mux select
- mem_req  out  1  port request, level
- mem_we  out  1  write flag of the winner
- mem_addr  out  N  muxed address
- mem_wdata  out  N  muxed write data
- mem_ack  in  1  memory accepted/completed, one-cycle pulse
- mem_rdata  in  N  read data, valid when `mem_ack`=1
- busy  out  1  1 in any state other than IDLE

## Operation
- States: IDLE, BUSY, DONE.
- Round-robin pointer `ptr` (2 bits) gives the highest-priority index. Search order: ptr, ptr+1, ptr+2, ptr+3, mod 4.
- IDLE:
  - If `req`≠0, register the winner into `sel`, set `gnt[winner]`=1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `mem_req`=1.
  - `mem_addr`, `mem_wdata` and `mem_we` come from the requester indexed by `sel`.
  - Wait counter increments each cycle.
  - On `mem_ack`: if `mem_we`=0, capture `mem_rdata` into `rdata`; go to DONE.
  - If the counter reaches MAX_WAIT with no ack: set the abort flag, leave `rdata` unchanged, go to DONE.
- DONE:
  - `done[sel]`=1 for one cycle, and `err`=abort flag.
  - `gnt` clears, `ptr`←sel+1 (wraps 3→0), counter clears.
  - Next state is IDLE.
- A requester holds `addr`, `wdata` and `we` stable while its `gnt` bit is 1.
- Dropping `req` during BUSY does not abort; the transaction completes normally.
- `req` is re-sampled only in IDLE. A requester that keeps `req` high after `done` competes again with rotated priority.
- `mem_ack` is ignored outside BUSY.
- `mem_addr` and `mem_wdata` are don't-care when `mem_req`=0; the implementation drives the `sel` mux output.
- Reset values: `gnt`=0, `done`=0, `err`=0, `rdata`=0, `sel`=0, `mem_req`=0, `mem_we`=0, `busy`=0, `ptr`=0, state IDLE, counter 0.
- Reset mid-transaction: return to IDLE next cycle. No `done` pulse for the dropped transaction; `ptr` returns to 0.

## Timing
- Request in IDLE at cycle t:
  - `gnt` and `sel` valid at t+1.
  - `mem_req` high from t+1.
- `mem_ack` at cycle a (a ≥ t+1): `done` and `rdata` valid at a+1; IDLE at a+2.
- Minimum request-to-done latency: 2 cycles (ack in the first BUSY cycle).
- Back-to-back throughput: one transaction per 3 cycles minimum.
- Watchdog: with no ack, `done` and `err` assert at t+1+MAX_WAIT.
- `gnt` is registered and glitch-free, and is exactly one-hot or zero.
- `done` and `err` are registered.

## Structure
- Shared package holds:
  - state enum {IDLE, BUSY, DONE}
  - NREQ=4 and SEL_W=2
  - watchdog counter width derived from MAX_WAIT
- Sub-module `rr_picker`: combinational; inputs `req[3:0]` and `ptr[1:0]`; outputs `winner[1:0]` and `any`.
- Instantiate the existing 4:1 N-bit mux twice, once for `mem_addr` and once for `mem_wdata`. Drive its 3-bit select as {1'b0, sel}.

## Test plan
- Reset, then `req`=4'b0001, read at addr0=0x100, ack in the 2nd BUSY cycle with `mem_rdata`=0xDEAD → `gnt`=0001 for 2 cycles, `done`=0001 one cycle later, `rdata`=0xDEAD, `ptr`=1.
- `req`=4'b1111 held constantly, ack immediate → grant order 0,1,2,3,0; `done` spaced 3 cycles apart.
- Write from requester 2 (`we`=0100, wdata2=0x55), `mem_rdata`=0xFFFF at ack → `mem_we`=1 and `mem_wdata`=0x55 during BUSY; `rdata` keeps its previous value.
- No ack, MAX_WAIT=15 → `done[sel]` and `err` pulse at t+16; `rdata` unchanged; next request is served normally.
- Reset asserted mid-BUSY → next cycle: all outputs 0, state IDLE, no `done`.
- `req[1]` dropped during BUSY, ack arrives → `done`=0010 still pulses.
